// File: rtl/bidir_piso_pkg.sv
// Shared types for the bidirectional shift-register library (serializer side).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bidir_piso_pkg;

    // PARITY is only reachable when the parity feature is compiled in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Shift direction encoding, common with the receive-side shifter.
    localparam logic DIR_RIGHT = 1'b0;  // LSB first
    localparam logic DIR_LEFT  = 1'b1;  // MSB first

endpackage

// File: rtl/bidir_piso_serializer.sv
// Parallel-in serial-out shifter, LSB-first or MSB-first selected per word at load.
// Latency: load at edge k -> data bits in cycles k+1..k+N, done pulse in cycle k+N+1
//          (parity build: parity bit in k+N+1, done in k+N+2).
// Backpressure: load_ready is high only in IDLE; the source holds load_valid until accepted.
//
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit after the data bits).
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   load_valid   source offers data_in/dir
//   load_ready   serializer idle and able to accept a word
//   data_in      N-bit word to transmit
//   dir          0 = LSB first, 1 = MSB first (captured at load only)
//   serial_out   current serial bit (0 when idle)
//   serial_valid serial_out carries a bit this cycle
//   busy         transfer in progress
//   done         one-cycle pulse in the first IDLE cycle after a transfer
module bidir_piso_serializer
    import bidir_piso_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] data_in,
    input  logic         dir,
    output logic         serial_out,
    output logic         serial_valid,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   sr_q;
    logic [CW-1:0]  cnt_q;
    logic           dir_q;
    logic           done_q;
    logic           load_fire;
    logic           last_bit;
    logic           finishing;

`ifdef PISO_PARITY_EN
    logic           parity_q;
`endif

    assign load_fire = load_valid && (state_q == IDLE);
    assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST);

    // The transfer ends on the edge leaving the last serial cycle; done is
    // registered from that so it lands in the first IDLE cycle.
`ifdef PISO_PARITY_EN
    assign finishing = (state_q == PARITY);
`else
    assign finishing = last_bit;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_ready   = 1'b0;
        serial_valid = 1'b0;
        busy         = 1'b0;
        serial_out   = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_fire) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                serial_valid = 1'b1;
                busy         = 1'b1;
                serial_out   = (dir_q == DIR_LEFT) ? sr_q[N-1] : sr_q[0];
                if (last_bit) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                serial_valid = 1'b1;
                busy         = 1'b1;
                serial_out   = parity_q;
                state_d      = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            dir_q    <= DIR_RIGHT;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= finishing;
            if (load_fire) begin
                sr_q     <= data_in;
                dir_q    <= dir;
                cnt_q    <= '0;
`ifdef PISO_PARITY_EN
                parity_q <= ^data_in;
`endif
            end else if (state_q == SHIFT) begin
                if (dir_q == DIR_LEFT) begin
                    sr_q <= {sr_q[N-2:0], 1'b0};
                end else begin
                    sr_q <= {1'b0, sr_q[N-1:1]};
                end
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_bidir_piso_serializer.sv
// Scoreboard bench for bidir_piso_serializer (N = 8). Build with +define+PISO_PARITY_EN
// to cover the parity variant. Expected serial sequences are written by hand,
// first transmitted bit leftmost.
module tb_bidir_piso_serializer;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic         load_valid;
    logic         load_ready;
    logic [N-1:0] data_in;
    logic         dir;
    logic         serial_out;
    logic         serial_valid;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic sv;
        logic so;
        logic dn;
    } item_t;

    item_t exp_q[$];

    bidir_piso_serializer #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .data_in      (data_in),
        .dir          (dir),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected item per cycle while a transfer is outstanding,
    // otherwise the outputs must be quiet.
    always @(negedge clk) begin
        item_t it;
        if (exp_q.size() > 0) begin
            it = exp_q.pop_front();
            checks++;
            if (serial_valid !== it.sv || serial_out !== it.so || done !== it.dn ||
                busy !== it.sv || load_ready !== !it.sv) begin
                errors++;
                $display("FAIL sb_item t=%0t: got sv=%b so=%b done=%b busy=%b rdy=%b, need sv=%b so=%b done=%b busy=%b rdy=%b",
                         $time, serial_valid, serial_out, done, busy, load_ready,
                         it.sv, it.so, it.dn, it.sv, !it.sv);
            end
        end else begin
            checks++;
            if (serial_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
                serial_out !== 1'b0 || load_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_quiet t=%0t: got sv=%b so=%b done=%b busy=%b rdy=%b, need 0 0 0 0 1",
                         $time, serial_valid, serial_out, done, busy, load_ready);
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b need %b", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_serial_out"},   serial_out,   1'b0);
        chk({tag, "_serial_valid"}, serial_valid, 1'b0);
        chk({tag, "_busy"},         busy,         1'b0);
        chk({tag, "_done"},         done,         1'b0);
        chk({tag, "_load_ready"},   load_ready,   1'b1);
    endtask

    // Offer a word and wait for acceptance; push nbits expected bits (all N plus
    // parity and done when nbits == N). Called just after a rising edge.
    task automatic do_load(input logic [N-1:0] d, input logic dr,
                           input logic [N-1:0] seq, input logic par, input int nbits);
        int guard;
        guard      = 0;
        load_valid = 1'b1;
        data_in    = d;
        dir        = dr;
        @(negedge clk);
        while (!load_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!load_ready) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: got load_ready=%b need 1 within 100 cycles", load_ready);
            @(posedge clk);
            #1 load_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            exp_q.push_back('{sv: 1'b1, so: seq[N-1-i], dn: 1'b0});
        end
        if (nbits == N) begin
`ifdef PISO_PARITY_EN
            exp_q.push_back('{sv: 1'b1, so: par, dn: 1'b0});
`else
            if (par === 1'bx) $display("note: parity argument unused in this build");
`endif
            exp_q.push_back('{sv: 1'b0, so: 1'b0, dn: 1'b1});
        end
        #1;
        load_valid = 1'b0;
        data_in    = '0;
        dir        = 1'b0;
    endtask

    task automatic settle();
        repeat (N + 5) @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = '0;
        dir        = 1'b0;

        // Power-up reset, with load_valid offered while in reset.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        load_valid = 1'b1;
        data_in    = 8'hA5;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        data_in    = '0;
        reset      = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // LSB-first 0x1E, parity 0.
        do_load(8'h1E, 1'b0, 8'b01111000, 1'b0, N);
        settle();
        // MSB-first 0x1E.
        do_load(8'h1E, 1'b1, 8'b00011110, 1'b0, N);
        settle();
        // LSB-first 0xC4 (odd weight).
        do_load(8'hC4, 1'b0, 8'b00100011, 1'b1, N);
        settle();

        // Hold load_valid with 0xFF and a toggling dir during a transfer,
        // then 0xFF MSB-first must be taken in the done cycle.
        do_load(8'h1E, 1'b0, 8'b01111000, 1'b0, N);
        load_valid = 1'b1;
        data_in    = 8'hFF;
        repeat (5) begin
            @(posedge clk);
            #1 dir = ~dir;
        end
        do_load(8'hFF, 1'b1, 8'b11111111, 1'b0, N);
        settle();

        // Reset while idle.
        reset = 1'b1;
        #1;
        chk_reset_outputs("idle_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset during the 4th bit: outputs clear at once, no done follows.
        do_load(8'h1E, 1'b1, 8'b00011110, 1'b0, 3);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        settle();
        do_load(8'h81, 1'b0, 8'b10000001, 1'b0, N);
        settle();

`ifdef PISO_PARITY_EN
        do_load(8'h07, 1'b0, 8'b11100000, 1'b1, N);
        settle();
        do_load(8'h03, 1'b0, 8'b11000000, 1'b0, N);
        settle();
`endif

        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d items left need 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bidir_piso_serializer.md
Name: bidir_piso_serializer

Overview:
- Parallel-in, serial-out shifter with selectable shift direction. It is the transmit-side counterpart of the bidirectional serial-in shift register.
- It accepts an N-bit word through a valid/ready load handshake, then emits one bit per clock, LSB-first or MSB-first. It pulses done after the last bit.
- Sits in front of any serial link or deserializer in the shift-register library.

Parameters:
- N, 8, data word width in bits; must be at least 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  source offers data_in and dir this cycle.
- load_ready  output  1  serializer can accept a word (high only in IDLE).
- data_in  input  N  parallel word to transmit.
- dir  input  1  0 = shift right (LSB first), 1 = shift left (MSB first); sampled only at load.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a valid bit this cycle.
- busy  output  1  a transfer is in progress (not IDLE).
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset port reset is asynchronous and active-high.
- Reset values: state=IDLE; shift register, bit counter and captured dir all 0; serial_out=0, serial_valid=0, busy=0, done=0, load_ready=1.
- States: IDLE and SHIFT; PARITY exists only with the optional feature.
- IDLE:
  - load_ready=1, serial_valid=0, serial_out=0.
  - On load_valid & load_ready at an edge: shift register <= data_in, dir_q <= dir, count <= 0, go to SHIFT.
- SHIFT:
  - serial_valid=1, busy=1, load_ready=0.
  - serial_out = dir_q ? sr[N-1] : sr[0], driven directly from the register with no extra latency.
  - Each edge: dir_q=0 gives sr <= {1'b0, sr[N-1:1]}; dir_q=1 gives sr <= {sr[N-2:0], 1'b0}; count <= count+1.
  - At the edge where count==N-1, the last bit has been presented; go to IDLE (or PARITY when enabled).
- Latency:
  - Load accepted at edge k; data bits presented in cycles k+1 .. k+N.
  - done=1 in cycle k+N+1 (the first IDLE cycle), registered, exactly one cycle.
- Throughput:
  - load_ready is high in the done cycle, so a back-to-back load is accepted there.
  - Sustained rate is one word per N+1 cycles.
- During SHIFT, load_valid, data_in and dir are ignored and nothing is captured. The source must hold load_valid until load_ready.
- Counter width: $clog2(N+1). It never wraps within a transfer and is cleared on every load.
- Reset mid-transfer: all outputs go to reset values immediately (asynchronously). The word is discarded, no done is issued, and the next load after release behaves normally.
- Reset and load_valid in the same cycle: reset wins, nothing is captured.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - At load, an even-parity bit (XOR reduction of data_in) is captured.
  - After the N data bits the FSM enters PARITY for one cycle: serial_out = parity bit, serial_valid=1, busy=1.
  - done then pulses in cycle k+N+2; throughput is one word per N+2 cycles.
- Undefined: no PARITY state and no parity register; behaviour is exactly as above.

Decomposition:
- Package bidir_piso_pkg:
  - State enum typedef: IDLE, SHIFT, PARITY.
  - Constants DIR_RIGHT=1'b0 and DIR_LEFT=1'b1, shared with the receive-side shifter.
- No sub-module: counter, FSM and shifter stay flat in one module.

Test Plan:
- Reset: assert reset mid-idle and at power-up -> all outputs 0, load_ready=1 on release; serial_valid stays 0 with no load.
- LSB-first: N=8, dir=0, load 8'h1E -> serial_out 0,1,1,1,1,0,0,0 with serial_valid=1 for 8 cycles; done pulse in the 9th cycle after the load edge.
- MSB-first: dir=1, load 8'h1E -> serial_out 0,0,0,1,1,1,1,0; done after the 8th bit.
- Hold and back-to-back:
  - Keep load_valid high during a transfer with data_in=8'hFF and dir toggling -> ignored, first word unaffected.
  - 8'hFF accepted in the done cycle -> eight 1s starting the next cycle.
- Reset mid-transfer: assert reset during bit 4 -> outputs 0 immediately, no done. Then load 8'h81 (dir=0) -> 1,0,0,0,0,0,0,1 correct.
- PISO_PARITY_EN: load 8'h07 (dir=0) -> bits 1,1,1,0,0,0,0,0 then parity bit 1 in cycle 9; done in cycle 10. Load 8'h03 -> parity 0.
